// File: rtl/action_fsm_timed_pkg.sv
// Shared types for the frame-stepped fencing action controller:
// saber-state output codes and the internal action state encoding.
package action_fsm_timed_pkg;

    localparam logic [1:0] IN_REST   = 2'b00;
    localparam logic [1:0] IN_LUNGE  = 2'b01;
    localparam logic [1:0] IN_BLOCK  = 2'b10;
    localparam logic [1:0] IN_ATTACK = 2'b11;

    typedef enum logic [2:0] {
        ST_REST,
        ST_LUNGE,
        ST_BLOCK,
        ST_ATTACK,
        ST_SCORE,
        ST_RECOVER,
        ST_KO
    } action_state_t;

    // SCORE, RECOVER and KO all present as a resting saber to the renderer.
    function automatic logic [1:0] saber_code(input action_state_t s);
        case (s)
            ST_LUNGE:  return IN_LUNGE;
            ST_BLOCK:  return IN_BLOCK;
            ST_ATTACK: return IN_ATTACK;
            default:   return IN_REST;
        endcase
    endfunction

endpackage

// File: rtl/action_fsm_timed_frame_timer.sv
// Per-state frame counter: clears on request, advances once per frame step,
// and sticks at all-ones so long waits never wrap back into a timeout match.
module action_fsm_timed_frame_timer #(
    parameter int TIMER_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_clr,
    input  logic                   i_step,
    output logic [TIMER_WIDTH-1:0] o_count
);

    logic [TIMER_WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_step && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/action_fsm_timed.sv
// Fencing action controller: gestures are captured between frames and the
// state machine, health and attack latch advance once per synchronised frame.
module action_fsm_timed
    import action_fsm_timed_pkg::*;
#(
    parameter int X_WIDTH               = 11,
    parameter int Y_WIDTH               = 10,
    parameter int HEALTH_WIDTH          = 3,
    parameter int MAX_HEALTH            = 5,
    parameter int TIMER_WIDTH           = 8,
    parameter int LUNGE_FRAMES          = 2,
    parameter int ATTACK_TIMEOUT_FRAMES = 30,
    parameter int BLOCK_MAX_FRAMES      = 60,
    parameter int RECOVER_FRAMES        = 15
) (
    input  logic                    clk_pixel_in,
    input  logic                    rst_n_in,
    input  logic                    block_in,
    input  logic                    lunge_in,
    input  logic                    release_in,
    input  logic                    ir_in_valid,
    input  logic                    frame_valid_in,
    input  logic [X_WIDTH-1:0]      saber_x_in,
    input  logic [Y_WIDTH-1:0]      saber_y_in,
    input  logic                    attack_hit_in,
    input  logic                    parry_hit_in,
    input  logic                    opponent_scored_in,
    input  logic                    new_round_in,
    output logic [1:0]              saber_state_out,
    output logic [X_WIDTH-1:0]      attack_x_out,
    output logic [Y_WIDTH-1:0]      attack_y_out,
    output logic [HEALTH_WIDTH-1:0] health_out,
    output logic                    player_scored_out,
    output logic                    ko_out,
    output logic                    data_out_valid
);

    localparam logic [TIMER_WIDTH-1:0]  LUNGE_LAST   = TIMER_WIDTH'(LUNGE_FRAMES - 1);
    localparam logic [TIMER_WIDTH-1:0]  ATTACK_LAST  = TIMER_WIDTH'(ATTACK_TIMEOUT_FRAMES - 1);
    localparam logic [TIMER_WIDTH-1:0]  BLOCK_LAST   = TIMER_WIDTH'(BLOCK_MAX_FRAMES - 1);
    localparam logic [TIMER_WIDTH-1:0]  RECOVER_LAST = TIMER_WIDTH'(RECOVER_FRAMES - 1);
    localparam logic [HEALTH_WIDTH-1:0] HEALTH_FULL  = HEALTH_WIDTH'(MAX_HEALTH);
    localparam logic [HEALTH_WIDTH-1:0] HEALTH_ONE   = HEALTH_WIDTH'(1);

    action_state_t          r_state, w_state_nxt;
    logic                   r_blk_sticky, r_lng_sticky, r_rel_sticky;
    logic                   w_blk, w_lng, w_rel;
    logic [TIMER_WIDTH-1:0] w_timer;
    logic                   w_timer_clr;

    logic [HEALTH_WIDTH-1:0] r_health, w_health_nxt;
    logic [X_WIDTH-1:0]      r_att_x, w_att_x_nxt;
    logic [Y_WIDTH-1:0]      r_att_y, w_att_y_nxt;
    logic                    r_scored, w_scored_nxt;
    logic                    r_dv;

    // A gesture seen on any cycle since the last step counts at this step.
    assign w_blk = r_blk_sticky | (ir_in_valid & block_in);
    assign w_lng = r_lng_sticky | (ir_in_valid & lunge_in);
    assign w_rel = r_rel_sticky | (ir_in_valid & release_in);

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_blk_sticky <= 1'b0;
            r_lng_sticky <= 1'b0;
            r_rel_sticky <= 1'b0;
        end else if (frame_valid_in) begin
            r_blk_sticky <= 1'b0;
            r_lng_sticky <= 1'b0;
            r_rel_sticky <= 1'b0;
        end else if (ir_in_valid) begin
            r_blk_sticky <= r_blk_sticky | block_in;
            r_lng_sticky <= r_lng_sticky | lunge_in;
            r_rel_sticky <= r_rel_sticky | release_in;
        end
    end

    assign w_timer_clr = frame_valid_in && (w_state_nxt != r_state);

    action_fsm_timed_frame_timer #(
        .TIMER_WIDTH (TIMER_WIDTH)
    ) u_frame_timer (
        .clk     (clk_pixel_in),
        .rst_n   (rst_n_in),
        .i_clr   (w_timer_clr),
        .i_step  (frame_valid_in),
        .o_count (w_timer)
    );

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= ST_REST;
        end else if (frame_valid_in) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (new_round_in) begin
            w_state_nxt = ST_REST;
        end else if (opponent_scored_in && (r_state != ST_KO)) begin
            w_state_nxt = (r_health <= HEALTH_ONE) ? ST_KO : ST_RECOVER;
        end else begin
            case (r_state)
                ST_REST: begin
                    if (w_blk)      w_state_nxt = ST_BLOCK;
                    else if (w_lng) w_state_nxt = ST_LUNGE;
                end
                ST_BLOCK: begin
                    if (w_rel || (w_timer == BLOCK_LAST)) w_state_nxt = ST_RECOVER;
                end
                ST_LUNGE: begin
                    if (w_timer == LUNGE_LAST) w_state_nxt = ST_ATTACK;
                end
                ST_ATTACK: begin
                    if (w_rel && attack_hit_in)                  w_state_nxt = ST_SCORE;
                    else if (w_rel || (w_timer == ATTACK_LAST)) w_state_nxt = ST_RECOVER;
                end
                ST_SCORE:   w_state_nxt = ST_RECOVER;
                ST_RECOVER: begin
                    if (w_timer == RECOVER_LAST) w_state_nxt = ST_REST;
                end
                default:    w_state_nxt = r_state;
            endcase
        end
    end

    // player_scored is high for exactly the step that produced the touch.
    always_comb begin
        w_health_nxt = r_health;
        w_att_x_nxt  = r_att_x;
        w_att_y_nxt  = r_att_y;
        w_scored_nxt = 1'b0;
        if (new_round_in) begin
            w_health_nxt = HEALTH_FULL;
            w_att_x_nxt  = '0;
            w_att_y_nxt  = '0;
        end else if (opponent_scored_in && (r_state != ST_KO)) begin
            w_health_nxt = (r_health == '0) ? '0 : r_health - 1'b1;
            w_scored_nxt = (r_state == ST_ATTACK) && w_rel && attack_hit_in;
        end else begin
            case (r_state)
                ST_REST: begin
                    if (!w_blk && w_lng) begin
                        w_att_x_nxt = saber_x_in;
                        w_att_y_nxt = saber_y_in;
                    end
                end
                ST_BLOCK:  w_scored_nxt = parry_hit_in;
                ST_ATTACK: w_scored_nxt = w_rel && attack_hit_in;
                default:   w_scored_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_health <= HEALTH_FULL;
            r_att_x  <= '0;
            r_att_y  <= '0;
            r_scored <= 1'b0;
            r_dv     <= 1'b0;
        end else begin
            r_dv <= frame_valid_in;
            if (frame_valid_in) begin
                r_health <= w_health_nxt;
                r_att_x  <= w_att_x_nxt;
                r_att_y  <= w_att_y_nxt;
                r_scored <= w_scored_nxt;
            end
        end
    end

    assign saber_state_out   = saber_code(r_state);
    assign ko_out            = (r_state == ST_KO);
    assign attack_x_out      = r_att_x;
    assign attack_y_out      = r_att_y;
    assign health_out        = r_health;
    assign player_scored_out = r_scored;
    assign data_out_valid    = r_dv;

endmodule

// File: tb/tb_action_fsm_timed.sv
// Bench for action_fsm_timed: each frame step queues its expected outputs,
// which are checked when the matching data_out_valid pulse appears.
module tb_action_fsm_timed;

    localparam int XW = 11;
    localparam int YW = 10;
    localparam int HW = 3;

    logic          clk_pixel_in = 1'b0;
    logic          rst_n_in = 1'b0;
    logic          block_in = 1'b0, lunge_in = 1'b0, release_in = 1'b0, ir_in_valid = 1'b0;
    logic          frame_valid_in = 1'b0;
    logic [XW-1:0] saber_x_in = '0;
    logic [YW-1:0] saber_y_in = '0;
    logic          attack_hit_in = 1'b0, parry_hit_in = 1'b0;
    logic          opponent_scored_in = 1'b0, new_round_in = 1'b0;
    logic [1:0]    saber_state_out;
    logic [XW-1:0] attack_x_out;
    logic [YW-1:0] attack_y_out;
    logic [HW-1:0] health_out;
    logic          player_scored_out, ko_out, data_out_valid;

    always #5 clk_pixel_in = ~clk_pixel_in;

    action_fsm_timed #(
        .X_WIDTH(XW), .Y_WIDTH(YW), .HEALTH_WIDTH(HW), .MAX_HEALTH(5), .TIMER_WIDTH(8),
        .LUNGE_FRAMES(2), .ATTACK_TIMEOUT_FRAMES(30), .BLOCK_MAX_FRAMES(60), .RECOVER_FRAMES(15)
    ) dut (
        .clk_pixel_in(clk_pixel_in), .rst_n_in(rst_n_in),
        .block_in(block_in), .lunge_in(lunge_in), .release_in(release_in),
        .ir_in_valid(ir_in_valid), .frame_valid_in(frame_valid_in),
        .saber_x_in(saber_x_in), .saber_y_in(saber_y_in),
        .attack_hit_in(attack_hit_in), .parry_hit_in(parry_hit_in),
        .opponent_scored_in(opponent_scored_in), .new_round_in(new_round_in),
        .saber_state_out(saber_state_out), .attack_x_out(attack_x_out),
        .attack_y_out(attack_y_out), .health_out(health_out),
        .player_scored_out(player_scored_out), .ko_out(ko_out),
        .data_out_valid(data_out_valid)
    );

    typedef struct {
        logic [1:0]    st;
        logic          sc;
        logic [HW-1:0] h;
        logic          ko;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        int            cyc;
        int            id;
    } exp_t;

    typedef struct {
        logic [2:0]    g;      // {block, lunge, release}
        logic          hit;
        logic          parry;
        logic          opp;
        logic          nr;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [1:0]    est;
        logic          esc;
        logic [HW-1:0] eh;
        logic          eko;
        logic [XW-1:0] ex;
        logic [YW-1:0] ey;
    } vec_t;

    exp_t          sb[$];
    exp_t          m_e;
    vec_t          tbl[6];
    int            compared = 0;
    int            mismatched = 0;
    int            cyc = 0;
    int            step_id = 0;
    logic [XW-1:0] drv_x = '0, exp_x = '0;
    logic [YW-1:0] drv_y = '0, exp_y = '0;

    always @(posedge clk_pixel_in) cyc <= cyc + 1;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s (step %0d): got %0d, expected %0d", nm, id, act, exp);
        end
    endtask

    always @(negedge clk_pixel_in) begin
        if (rst_n_in && data_out_valid) begin
            if (sb.size() == 0) begin
                chk("dv_without_step", cyc, 32'd1, 32'd0);
            end else begin
                m_e = sb.pop_front();
                chk("latency",       m_e.id, cyc,               m_e.cyc);
                chk("saber_state",   m_e.id, saber_state_out,   m_e.st);
                chk("player_scored", m_e.id, player_scored_out, m_e.sc);
                chk("health",        m_e.id, health_out,        m_e.h);
                chk("ko",            m_e.id, ko_out,            m_e.ko);
                chk("attack_x",      m_e.id, attack_x_out,      m_e.x);
                chk("attack_y",      m_e.id, attack_y_out,      m_e.y);
            end
        end
    end

    // Called #1 after a rising edge; the step lands on the next rising edge.
    task automatic do_step(input logic [2:0] g, input logic hit, input logic parry,
                           input logic opp, input logic nr,
                           input logic [XW-1:0] x, input logic [YW-1:0] y,
                           input logic [1:0] est, input logic esc, input logic [HW-1:0] eh,
                           input logic eko, input logic [XW-1:0] ex, input logic [YW-1:0] ey);
        exp_t e;
        block_in = g[2]; lunge_in = g[1]; release_in = g[0]; ir_in_valid = |g;
        attack_hit_in = hit; parry_hit_in = parry;
        opponent_scored_in = opp; new_round_in = nr;
        saber_x_in = x; saber_y_in = y;
        frame_valid_in = 1'b1;
        step_id++;
        e.st = est; e.sc = esc; e.h = eh; e.ko = eko; e.x = ex; e.y = ey;
        e.cyc = cyc + 1; e.id = step_id;
        sb.push_back(e);
        @(posedge clk_pixel_in); #1;
        block_in = 1'b0; lunge_in = 1'b0; release_in = 1'b0; ir_in_valid = 1'b0;
        attack_hit_in = 1'b0; parry_hit_in = 1'b0;
        opponent_scored_in = 1'b0; new_round_in = 1'b0;
        frame_valid_in = 1'b0;
    endtask

    task automatic step(input logic [2:0] g, input logic hit, input logic parry,
                        input logic opp, input logic nr,
                        input logic [1:0] est, input logic esc, input logic [HW-1:0] eh,
                        input logic eko);
        do_step(g, hit, parry, opp, nr, drv_x, drv_y, est, esc, eh, eko, exp_x, exp_y);
    endtask

    // 14 more RECOVER steps with lunge gestures that must be discarded,
    // then the step that returns to REST.
    task automatic recover_to_rest(input logic [HW-1:0] h);
        for (int i = 0; i < 14; i++) step(3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, h, 1'b0);
        step(3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, h, 1'b0);
    endtask

    initial begin
        tbl[0] = '{3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0,   10'd0,   2'b00, 1'b0, 3'd5, 1'b0, 11'd0,   10'd0};
        tbl[1] = '{3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 11'd400, 10'd300, 2'b01, 1'b0, 3'd5, 1'b0, 11'd400, 10'd300};
        tbl[2] = '{3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 11'd10,  10'd20,  2'b01, 1'b0, 3'd5, 1'b0, 11'd400, 10'd300};
        tbl[3] = '{3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 11'd10,  10'd20,  2'b11, 1'b0, 3'd5, 1'b0, 11'd400, 10'd300};
        tbl[4] = '{3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 11'd10,  10'd20,  2'b00, 1'b1, 3'd5, 1'b0, 11'd400, 10'd300};
        tbl[5] = '{3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 11'd10,  10'd20,  2'b00, 1'b0, 3'd5, 1'b0, 11'd400, 10'd300};

        repeat (2) @(posedge clk_pixel_in);
        #1;
        chk("reset_saber_state", 0, saber_state_out,   2'b00);
        chk("reset_health",      0, health_out,        3'd5);
        chk("reset_ko",          0, ko_out,            1'b0);
        chk("reset_scored",      0, player_scored_out, 1'b0);
        chk("reset_attack_x",    0, attack_x_out,      11'd0);
        chk("reset_attack_y",    0, attack_y_out,      10'd0);
        chk("reset_dv",          0, data_out_valid,    1'b0);
        rst_n_in = 1'b1;
        @(posedge clk_pixel_in); #1;

        // Idle step, lunge/latch, release ignored in LUNGE, scoring attack.
        for (int i = 0; i < 6; i++)
            do_step(tbl[i].g, tbl[i].hit, tbl[i].parry, tbl[i].opp, tbl[i].nr, tbl[i].x, tbl[i].y,
                    tbl[i].est, tbl[i].esc, tbl[i].eh, tbl[i].eko, tbl[i].ex, tbl[i].ey);
        drv_x = 11'd10; drv_y = 10'd20; exp_x = 11'd400; exp_y = 10'd300;
        recover_to_rest(3'd5);

        // Attack held without release times out into RECOVER.
        drv_x = 11'd100; drv_y = 10'd50; exp_x = 11'd100; exp_y = 10'd50;
        step(3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 3'd5, 1'b0);
        step(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 3'd5, 1'b0);
        step(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 3'd5, 1'b0);
        for (int i = 0; i < 29; i++) step(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 3'd5, 1'b0);
        step(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'd5, 1'b0);
        recover_to_rest(3'd5);

        // Block and lunge captured between steps: block wins, attack latch untouched.
        ir_in_valid = 1'b1; block_in = 1'b1; lunge_in = 1'b1; drv_x = 11'd900; drv_y = 10'd700;
        @(posedge clk_pixel_in); #1;
        ir_in_valid = 1'b0; block_in = 1'b0; lunge_in = 1'b0;
        step(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 3'd5, 1'b0);
        step(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 3'd5, 1'b0);
        for (int i = 0; i < 58; i++) step(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 3'd5, 1'b0);
        step(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'd5, 1'b0);
        recover_to_rest(3'd5);

        // Release ends a block early.
        step(3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 3'd5, 1'b0);
        step(3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'd5, 1'b0);
        recover_to_rest(3'd5);

        // Double touch, then health runs down to KO; KO ignores everything but new round.
        drv_x = 11'd200; drv_y = 10'd150; exp_x = 11'd200; exp_y = 10'd150;
        step(3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 3'd5, 1'b0);
        step(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 3'd5, 1'b0);
        step(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 3'd5, 1'b0);
        step(3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 3'd4, 1'b0);
        step(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 3'd3, 1'b0);
        step(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 3'd2, 1'b0);
        step(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 3'd1, 1'b0);
        step(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 3'd0, 1'b1);
        step(3'b110, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 3'd0, 1'b1);
        exp_x = 11'd0; exp_y = 10'd0;
        step(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 3'd5, 1'b0);

        // Opponent touch from REST, then into ATTACK for the asynchronous reset.
        step(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 3'd4, 1'b0);
        recover_to_rest(3'd4);
        drv_x = 11'd7; drv_y = 10'd9; exp_x = 11'd7; exp_y = 10'd9;
        step(3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 3'd4, 1'b0);
        step(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 3'd4, 1'b0);
        step(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 3'd4, 1'b0);
        step(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 3'd4, 1'b0);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("async_rst_saber_state", step_id, saber_state_out, 2'b00);
        chk("async_rst_health",      step_id, health_out,      3'd5);
        chk("async_rst_attack_x",    step_id, attack_x_out,    11'd0);
        chk("async_rst_attack_y",    step_id, attack_y_out,    10'd0);
        chk("async_rst_ko",          step_id, ko_out,          1'b0);
        chk("async_rst_dv_dropped",  step_id, data_out_valid,  1'b0);
        sb.delete();
        @(posedge clk_pixel_in); #1;
        rst_n_in = 1'b1;
        @(posedge clk_pixel_in); #1;
        exp_x = 11'd0; exp_y = 10'd0;
        step(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'd5, 1'b0);
        drv_x = 11'd55; drv_y = 10'd66; exp_x = 11'd55; exp_y = 10'd66;
        step(3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 3'd5, 1'b0);

        repeat (3) @(posedge clk_pixel_in);
        #1;
        chk("all_steps_reported", step_id, sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
